mem_port_arbiter: RTL

- Shares the single byte-wide synchronous memory port between two requesters.
  - Port 0: the CPU's memory_control byte interface.
  - Port 1: a loader/debug master, used for program load and memory inspection.
- Round-robin arbitration with transaction locking. A grant is held until its owner drops req, so multi-byte word accesses are never interleaved.
- Read-data valid strobes are routed to the owner that issued each read.
- A watchdog flags an owner that holds the port too long while the other port waits.

---
 rtl/arch_defines.sv | 10 +
 rtl/arb_hold_watchdog.sv | 24 ++
 rtl/mem_port_arbiter.sv | 68 ++++++
 3 files changed

// File: rtl/arch_defines.sv
// arch_defines: shared state encodings and port indices for the memory port arbiter
package arch_defines;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;
  localparam logic ARB_PORT_CPU    = 1'b0;
  localparam logic ARB_PORT_LOADER = 1'b1;
endpackage

// File: rtl/arb_hold_watchdog.sv
// arb_hold_watchdog: saturating hold counter with sticky timeout flag
module arb_hold_watchdog #(
  parameter int MAX_HOLD = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic timeout
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt, cnt_n;
  always_comb cnt_n = (clear || !count_en) ? '0 : (cnt == CW'(MAX_HOLD)) ? cnt : cnt + 1'b1;
  // flag follows the next count so it is visible in the cycle the count saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      timeout <= timeout | (cnt_n == CW'(MAX_HOLD));
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: locking round-robin arbiter sharing one byte memory port between two masters
module mem_port_arbiter
  import arch_defines::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  we0,
  output logic                  gnt0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  we1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  hold_timeout
);
  arb_state_t state, state_n, pick;
  logic last_winner, keep, iss0, iss1;
  assign gnt0 = state == ARB_OWN0;
  assign gnt1 = state == ARB_OWN1;
  assign keep = (gnt0 && req0) || (gnt1 && req1);
  // a releasing owner has dropped its req, so the tie term only fires from IDLE
  assign pick = (req0 && req1) ? (last_winner ? ARB_OWN0 : ARB_OWN1) :
                req0 ? ARB_OWN0 : req1 ? ARB_OWN1 : ARB_IDLE;
  assign state_n = keep ? state : pick;
  assign iss0 = gnt0 && req0 && !rst;
  assign iss1 = gnt1 && req1 && !rst;
  assign mem_addr  = iss0 ? addr0 : iss1 ? addr1 : '0;
  assign mem_wdata = iss0 ? wdata0 : iss1 ? wdata1 : '0;
  assign mem_we    = (iss0 && we0) || (iss1 && we1);
  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      last_winner <= ARB_PORT_LOADER;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state && state_n != ARB_IDLE)
        last_winner <= (state_n == ARB_OWN1) ? ARB_PORT_LOADER : ARB_PORT_CPU;
      rvalid0 <= iss0 && !we0;
      rvalid1 <= iss1 && !we1;
    end
  end
  arb_hold_watchdog #(.MAX_HOLD(MAX_HOLD)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_n != state),
    .count_en ((gnt0 && req1) || (gnt1 && req0)),
    .timeout  (hold_timeout)
  );
endmodule
